mpsoc4d_ahb4_ext_arbiter: RTL and testbench

- Round-robin AHB-Lite arbiter that shares the single external AHB4 slave port (ahb4_ext_*) of mpsoc4d_riscv between NUM_MASTERS tile-side masters.
- Sits between the tile bus bridges and the system-level ahb4_ext port.
- Grants ownership per burst, honours hmastlock, and stalls non-owners through their hready.
- Tracks the data-phase owner so that hwdata, hrdata and hresp are steered correctly.

---
 rtl/mpsoc4d_ahb4_ext_arbiter_pkg.sv | 27 ++
 rtl/mpsoc4d_rr_pick.sv | 25 ++
 rtl/mpsoc4d_ahb4_ext_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mpsoc4d_ahb4_ext_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpsoc4d_ahb4_ext_arbiter_pkg.sv
// Shared AHB4 encodings used by the tile bridges and the external-port arbiter.
package mpsoc4d_ahb4_ext_arbiter_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic {
    ARB_UNOWNED = 1'b0,
    ARB_OWNED   = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mpsoc4d_rr_pick.sv
// Combinational round-robin picker: first requester above rr_last_i, wrapping at N.
module mpsoc4d_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] rr_last_i,
  output logic [IDX_W-1:0] pick_o,
  output logic             valid_o
);

  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!valid_o && req_i[i] && (((int'(rr_last_i) + k) % N) == i)) begin
          valid_o = 1'b1;
          pick_o  = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mpsoc4d_ahb4_ext_arbiter.sv
// Round-robin AHB-Lite arbiter sharing the external AHB4 slave port between
// NUM_MASTERS tile masters; ownership changes only on an accepted, unlocked IDLE.
module mpsoc4d_ahb4_ext_arbiter
  import mpsoc4d_ahb4_ext_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int PLEN        = 32,
  parameter int XLEN        = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_MASTERS*PLEN-1:0] m_haddr_i,
  input  logic [NUM_MASTERS*XLEN-1:0] m_hwdata_i,
  input  logic [NUM_MASTERS-1:0]      m_hwrite_i,
  input  logic [NUM_MASTERS*3-1:0]    m_hsize_i,
  input  logic [NUM_MASTERS*3-1:0]    m_hburst_i,
  input  logic [NUM_MASTERS*4-1:0]    m_hprot_i,
  input  logic [NUM_MASTERS*2-1:0]    m_htrans_i,
  input  logic [NUM_MASTERS-1:0]      m_hmastlock_i,
  output logic [NUM_MASTERS*XLEN-1:0] m_hrdata_o,
  output logic [NUM_MASTERS-1:0]      m_hready_o,
  output logic [NUM_MASTERS-1:0]      m_hresp_o,
  output logic                        ahb4_ext_hsel_o,
  output logic [PLEN-1:0]             ahb4_ext_haddr_o,
  output logic [XLEN-1:0]             ahb4_ext_hwdata_o,
  output logic                        ahb4_ext_hwrite_o,
  output logic [2:0]                  ahb4_ext_hsize_o,
  output logic [2:0]                  ahb4_ext_hburst_o,
  output logic [3:0]                  ahb4_ext_hprot_o,
  output logic [1:0]                  ahb4_ext_htrans_o,
  output logic                        ahb4_ext_hmastlock_o,
  input  logic [XLEN-1:0]             ahb4_ext_hrdata_i,
  input  logic                        ahb4_ext_hready_i,
  input  logic                        ahb4_ext_hresp_i
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d, rr_last_q, rr_last_d;
  logic [IDX_W-1:0] data_owner_q, data_owner_d;
  logic             data_valid_q, data_valid_d;

  logic [NUM_MASTERS-1:0] req, arb_req;
  logic [IDX_W-1:0]       pick;
  logic                   pick_vld;
  logic [PLEN-1:0]        own_haddr;
  logic [XLEN-1:0]        dph_hwdata;
  logic [2:0]             own_hsize, own_hburst;
  logic [3:0]             own_hprot;
  logic [1:0]             own_htrans;
  logic                   own_hwrite, own_lock, rearb;

  // While owned, the current owner is excluded so a waiting master always wins the handover.
  always_comb begin
    own_haddr  = '0;
    own_hsize  = '0;
    own_hburst = '0;
    own_hprot  = '0;
    own_htrans = '0;
    own_hwrite = 1'b0;
    own_lock   = 1'b0;
    dph_hwdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      req[i]     = m_htrans_i[i*2+1];
      arb_req[i] = m_htrans_i[i*2+1] &
                   !((state_q == ARB_OWNED) && (owner_q == IDX_W'(i)));
      if (owner_q == IDX_W'(i)) begin
        own_haddr  = m_haddr_i[i*PLEN +: PLEN];
        own_hsize  = m_hsize_i[i*3 +: 3];
        own_hburst = m_hburst_i[i*3 +: 3];
        own_hprot  = m_hprot_i[i*4 +: 4];
        own_htrans = m_htrans_i[i*2 +: 2];
        own_hwrite = m_hwrite_i[i];
        own_lock   = m_hmastlock_i[i];
      end
      if (data_owner_q == IDX_W'(i)) begin
        dph_hwdata = m_hwdata_i[i*XLEN +: XLEN];
      end
    end
  end

  mpsoc4d_rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i     (arb_req),
    .rr_last_i (rr_last_q),
    .pick_o    (pick),
    .valid_o   (pick_vld)
  );

  assign rearb = (state_q == ARB_OWNED) && ahb4_ext_hready_i &&
                 (own_htrans == HTRANS_IDLE) && !own_lock && pick_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_UNOWNED;
      owner_q      <= '0;
      rr_last_q    <= IDX_W'(NUM_MASTERS - 1);
      data_owner_q <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_last_q    <= rr_last_d;
      data_owner_q <= data_owner_d;
      data_valid_q <= data_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_last_d    = rr_last_q;
    data_owner_d = data_owner_q;
    data_valid_d = data_valid_q;
    case (state_q)
      ARB_UNOWNED: begin
        data_valid_d = 1'b0;
        if (pick_vld) begin
          state_d   = ARB_OWNED;
          owner_d   = pick;
          rr_last_d = pick;
        end
      end
      default: begin
        if (ahb4_ext_hready_i) begin
          data_owner_d = owner_q;
          data_valid_d = own_htrans[1];
        end
        if (rearb) begin
          owner_d   = pick;
          rr_last_d = pick;
        end
      end
    endcase
  end

  assign m_hrdata_o = {NUM_MASTERS{ahb4_ext_hrdata_i}};

  always_comb begin
    ahb4_ext_hsel_o      = 1'b0;
    ahb4_ext_haddr_o     = '0;
    ahb4_ext_hwrite_o    = 1'b0;
    ahb4_ext_hsize_o     = '0;
    ahb4_ext_hburst_o    = '0;
    ahb4_ext_hprot_o     = '0;
    ahb4_ext_htrans_o    = HTRANS_IDLE;
    ahb4_ext_hmastlock_o = 1'b0;
    ahb4_ext_hwdata_o    = data_valid_q ? dph_hwdata : '0;
    if (state_q == ARB_OWNED) begin
      ahb4_ext_hsel_o      = 1'b1;
      ahb4_ext_haddr_o     = own_haddr;
      ahb4_ext_hwrite_o    = own_hwrite;
      ahb4_ext_hsize_o     = own_hsize;
      ahb4_ext_hburst_o    = own_hburst;
      ahb4_ext_hprot_o     = own_hprot;
      ahb4_ext_htrans_o    = own_htrans;
      ahb4_ext_hmastlock_o = own_lock;
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_hready_o[i] = !req[i];
      m_hresp_o[i]  = 1'b0;
      if ((state_q == ARB_OWNED) && (owner_q == IDX_W'(i))) begin
        m_hready_o[i] = ahb4_ext_hready_i;
      end
      if (data_owner_q == IDX_W'(i)) begin
        m_hresp_o[i] = ahb4_ext_hresp_i;
      end
    end
  end

endmodule

// File: tb/tb_mpsoc4d_ahb4_ext_arbiter.sv
// Directed bench for the external AHB4 arbiter: grant order, burst/lock hold,
// wait states, error steering and reset.
module tb_mpsoc4d_ahb4_ext_arbiter;
  localparam int N    = 4;
  localparam int PLEN = 32;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N*PLEN-1:0] m_haddr;
  logic [N*XLEN-1:0] m_hwdata;
  logic [N-1:0]      m_hwrite;
  logic [N*3-1:0]    m_hsize;
  logic [N*3-1:0]    m_hburst;
  logic [N*4-1:0]    m_hprot;
  logic [N*2-1:0]    m_htrans;
  logic [N-1:0]      m_hmastlock;
  logic [N*XLEN-1:0] m_hrdata;
  logic [N-1:0]      m_hready;
  logic [N-1:0]      m_hresp;
  logic              s_hsel;
  logic [PLEN-1:0]   s_haddr;
  logic [XLEN-1:0]   s_hwdata;
  logic              s_hwrite;
  logic [2:0]        s_hsize;
  logic [2:0]        s_hburst;
  logic [3:0]        s_hprot;
  logic [1:0]        s_htrans;
  logic              s_hmastlock;
  logic [XLEN-1:0]   s_hrdata;
  logic              s_hready;
  logic              s_hresp;

  int vectors     = 0;
  int miscompares = 0;

  mpsoc4d_ahb4_ext_arbiter #(
    .NUM_MASTERS (N),
    .PLEN        (PLEN),
    .XLEN        (XLEN)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .m_haddr_i            (m_haddr),
    .m_hwdata_i           (m_hwdata),
    .m_hwrite_i           (m_hwrite),
    .m_hsize_i            (m_hsize),
    .m_hburst_i           (m_hburst),
    .m_hprot_i            (m_hprot),
    .m_htrans_i           (m_htrans),
    .m_hmastlock_i        (m_hmastlock),
    .m_hrdata_o           (m_hrdata),
    .m_hready_o           (m_hready),
    .m_hresp_o            (m_hresp),
    .ahb4_ext_hsel_o      (s_hsel),
    .ahb4_ext_haddr_o     (s_haddr),
    .ahb4_ext_hwdata_o    (s_hwdata),
    .ahb4_ext_hwrite_o    (s_hwrite),
    .ahb4_ext_hsize_o     (s_hsize),
    .ahb4_ext_hburst_o    (s_hburst),
    .ahb4_ext_hprot_o     (s_hprot),
    .ahb4_ext_htrans_o    (s_htrans),
    .ahb4_ext_hmastlock_o (s_hmastlock),
    .ahb4_ext_hrdata_i    (s_hrdata),
    .ahb4_ext_hready_i    (s_hready),
    .ahb4_ext_hresp_i     (s_hresp)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int i, input logic [1:0] t, input logic [31:0] a, input logic lk);
    m_htrans[i*2 +: 2]       = t;
    m_haddr[i*PLEN +: PLEN]  = a;
    m_hmastlock[i]           = lk;
  endtask

  initial begin
    m_haddr = '0; m_hwdata = '0; m_hwrite = '0; m_hsize = '0;
    m_hburst = '0; m_hprot = '0; m_htrans = '0; m_hmastlock = '0;
    s_hrdata = '0; s_hready = 1'b1; s_hresp = 1'b0;

    rst = 1'b1;
    repeat (3) tick();
    check_vec("rst_hsel", s_hsel, 0);
    check_vec("rst_htrans", s_htrans, 0);
    check_vec("rst_haddr", s_haddr, 0);
    check_vec("rst_hwdata", s_hwdata, 0);
    check_vec("rst_mready", m_hready, 4'hF);
    check_vec("rst_mresp", m_hresp, 4'h0);
    rst = 1'b0;

    // single master write
    drive_m(0, 2'd2, 32'h1000, 1'b0);
    m_hwrite[0] = 1'b1;
    m_hwdata[31:0] = 32'hDEADBEEF;
    #1;
    check_vec("t1_stall", m_hready, 4'b1110);
    check_vec("t1_hsel_unowned", s_hsel, 0);
    tick();
    check_vec("t1_haddr", s_haddr, 32'h1000);
    check_vec("t1_htrans", s_htrans, 2);
    check_vec("t1_hwrite", s_hwrite, 1);
    check_vec("t1_mready", m_hready, 4'b1111);
    tick();
    drive_m(0, 2'd0, 32'h1000, 1'b0);
    #1;
    check_vec("t1_hwdata", s_hwdata, 32'hDEADBEEF);
    check_vec("t1_idle", s_htrans, 0);
    tick();
    check_vec("t1_hwdata_done", s_hwdata, 0);
    check_vec("t1_parked_hsel", s_hsel, 1);
    m_hwrite[0] = 1'b0;

    // contention between M0, M1, M2
    drive_m(0, 2'd2, 32'h100, 1'b0);
    drive_m(1, 2'd2, 32'h200, 1'b0);
    drive_m(2, 2'd2, 32'h300, 1'b0);
    #1;
    check_vec("t2_g0_haddr", s_haddr, 32'h100);
    check_vec("t2_g0_mready", m_hready, 4'b1001);
    tick();
    drive_m(0, 2'd0, 32'h100, 1'b0);
    #1;
    check_vec("t2_g0_idle", s_htrans, 0);
    check_vec("t2_g0_idle_mready", m_hready, 4'b1001);
    tick();
    check_vec("t2_g1_haddr", s_haddr, 32'h200);
    check_vec("t2_g1_mready", m_hready, 4'b1011);
    tick();
    drive_m(1, 2'd0, 32'h200, 1'b0);
    tick();
    check_vec("t2_g2_haddr", s_haddr, 32'h300);
    check_vec("t2_g2_mready", m_hready, 4'b1111);
    tick();
    drive_m(2, 2'd0, 32'h300, 1'b0);
    tick();

    // INCR4 burst on M1 while M3 requests
    drive_m(1, 2'd2, 32'h400, 1'b0);
    m_hburst[5:3] = 3'd3;
    #1;
    check_vec("t3_req_stall", m_hready, 4'b1101);
    tick();
    check_vec("t3_nonseq", s_htrans, 2);
    check_vec("t3_haddr", s_haddr, 32'h400);
    check_vec("t3_hburst", s_hburst, 3);
    tick();
    drive_m(1, 2'd3, 32'h404, 1'b0);
    drive_m(3, 2'd2, 32'h800, 1'b0);
    #1;
    check_vec("t3_seq1", s_htrans, 3);
    check_vec("t3_m3_stall", m_hready, 4'b0111);
    tick();
    drive_m(1, 2'd3, 32'h408, 1'b0);
    #1;
    check_vec("t3_seq2", s_htrans, 3);
    check_vec("t3_seq2_haddr", s_haddr, 32'h408);
    tick();
    drive_m(1, 2'd3, 32'h40C, 1'b0);
    #1;
    check_vec("t3_seq3", s_htrans, 3);
    tick();
    drive_m(1, 2'd0, 32'h0, 1'b0);
    m_hburst[5:3] = 3'd0;
    #1;
    check_vec("t3_idle", s_htrans, 0);
    check_vec("t3_idle_mready", m_hready, 4'b0111);
    tick();
    check_vec("t3_m3_nonseq", s_htrans, 2);
    check_vec("t3_m3_haddr", s_haddr, 32'h800);
    tick();
    drive_m(3, 2'd0, 32'h800, 1'b0);

    // locked sequence on M0 while M2 requests
    drive_m(0, 2'd2, 32'h500, 1'b1);
    tick();
    check_vec("t4_haddr", s_haddr, 32'h500);
    check_vec("t4_lock", s_hmastlock, 1);
    tick();
    drive_m(0, 2'd0, 32'h504, 1'b1);
    drive_m(2, 2'd2, 32'h600, 1'b0);
    #1;
    check_vec("t4_idle_locked", s_hmastlock, 1);
    check_vec("t4_m2_stall", m_hready, 4'b1011);
    tick();
    check_vec("t4_hold_haddr", s_haddr, 32'h504);
    drive_m(0, 2'd2, 32'h508, 1'b1);
    #1;
    check_vec("t4_locked_nonseq", s_haddr, 32'h508);
    tick();
    drive_m(0, 2'd0, 32'h50C, 1'b0);
    #1;
    check_vec("t4_unlock_owner", s_haddr, 32'h50C);
    check_vec("t4_unlock_lock", s_hmastlock, 0);
    tick();
    check_vec("t4_m2_haddr", s_haddr, 32'h600);
    check_vec("t4_m2_htrans", s_htrans, 2);
    check_vec("t4_m2_mready", m_hready, 4'b1111);

    // wait states then ERROR on M2's read
    tick();
    drive_m(2, 2'd0, 32'h600, 1'b0);
    drive_m(0, 2'd2, 32'h700, 1'b0);
    s_hready = 1'b0;
    #1;
    check_vec("t5_wait_mready", m_hready, 4'b1010);
    check_vec("t5_wait_mresp", m_hresp, 4'b0000);
    tick();
    check_vec("t5_wait2_mready", m_hready, 4'b1010);
    tick();
    s_hresp = 1'b1;
    #1;
    check_vec("t5_err1_mresp", m_hresp, 4'b0100);
    check_vec("t5_err1_mready", m_hready, 4'b1010);
    tick();
    s_hready = 1'b1;
    s_hrdata = 32'hCAFE0001;
    #1;
    check_vec("t5_err2_mresp", m_hresp, 4'b0100);
    check_vec("t5_err2_mready", m_hready, 4'b1110);
    check_vec("t5_rdata", m_hrdata[2*XLEN +: XLEN], 32'hCAFE0001);
    tick();
    s_hresp = 1'b0;
    #1;
    check_vec("t5_m0_granted", s_haddr, 32'h700);
    check_vec("t5_mresp_clear", m_hresp, 4'b0000);

    // reset in the middle of an M1 burst
    tick();
    drive_m(0, 2'd0, 32'h700, 1'b0);
    drive_m(1, 2'd2, 32'h900, 1'b0);
    tick();
    check_vec("t6_m1_haddr", s_haddr, 32'h900);
    tick();
    drive_m(1, 2'd3, 32'h904, 1'b0);
    #1;
    check_vec("t6_seq", s_htrans, 3);
    rst = 1'b1;
    drive_m(1, 2'd0, 32'h0, 1'b0);
    tick();
    check_vec("t6_rst_hsel", s_hsel, 0);
    check_vec("t6_rst_htrans", s_htrans, 0);
    check_vec("t6_rst_mready", m_hready, 4'hF);
    check_vec("t6_rst_hwdata", s_hwdata, 0);
    rst = 1'b0;

    // rr_last restarts at NUM_MASTERS-1, so M1 beats M2
    drive_m(1, 2'd2, 32'hA00, 1'b0);
    drive_m(2, 2'd2, 32'hB00, 1'b0);
    tick();
    check_vec("t7_rr_after_rst", s_haddr, 32'hA00);
    check_vec("t7_mready", m_hready, 4'b1011);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
